// File: rtl/sprite_plotter.sv
// Sprite rectangle scanner: walks a W x H sprite from a synchronous ROM and emits clipped pixel writes.
// Optional feature macro: SPRITE_TRANSPARENT_EN (colour 0 is not plotted during a draw).
module sprite_plotter #(
  parameter int         W         = 8,
  parameter int         H         = 8,
  parameter int         ADDR_W    = 6,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_x,
  input  logic [6:0]        req_y,
  input  logic              req_erase,
  output logic [ADDR_W-1:0] spr_addr,
  input  logic [2:0]        spr_data,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot,
  output logic              done
);

  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

  state_t         state_q;
  logic [CXW-1:0] cx_q, cx_d;
  logic [CYW-1:0] cy_q, cy_d;
  logic [7:0]     ox_q;
  logic [6:0]     oy_q;
  logic           erase_q;
  logic [8:0]     px_q;
  logic [7:0]     py_q;
  logic           s1_valid_q;
  logic           ready_q, done_q, plot_q;
  logic [7:0]     x_q;
  logic [6:0]     y_q;
  logic [2:0]     colour_q;
  logic           last_pix, plot_d;
  logic [2:0]     colour_d;

  assign spr_addr = ADDR_W'(int'(cy_q) * W + int'(cx_q));

  always_comb begin
    last_pix = (cx_q == CXW'(W - 1)) && (cy_q == CYW'(H - 1));
    cx_d     = cx_q + CXW'(1);
    cy_d     = cy_q;
    if (cx_q == CXW'(W - 1)) begin
      cx_d = '0;
      cy_d = cy_q + CYW'(1);
    end
    colour_d = erase_q ? BG_COLOUR : spr_data;
    // Sums are kept one bit wider than the screen coordinates so off-screen pixels never alias.
    plot_d   = s1_valid_q && (px_q < 9'(SCREEN_W)) && (py_q < 8'(SCREEN_H));
`ifdef SPRITE_TRANSPARENT_EN
    if (!erase_q && (spr_data == 3'b000)) plot_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      erase_q    <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      s1_valid_q <= 1'b0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      plot_q     <= plot_d;
      x_q        <= px_q[7:0];
      y_q        <= py_q[6:0];
      colour_q   <= colour_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ox_q    <= req_x;
            oy_q    <= req_y;
            erase_q <= req_erase;
            cx_q    <= '0;
            cy_q    <= '0;
            ready_q <= 1'b0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          px_q       <= {1'b0, ox_q} + 9'(cx_q);
          py_q       <= {1'b0, oy_q} + 8'(cy_q);
          s1_valid_q <= 1'b1;
          if (last_pix) begin
            cx_q    <= '0;
            cy_q    <= '0;
            state_q <= S_FLUSH;
          end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
          end
        end
        S_FLUSH: begin
          // The last pixel reaches the outputs on this edge, so done lines up with it.
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomized and directed bench for sprite_plotter against a per-pixel reference model.
module tb_sprite_plotter;

  localparam int NW = 8;
  localparam int NH = 8;
  localparam int N  = NW * NH;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic       req_erase;
  logic [5:0] spr_addr;
  logic [2:0] spr_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  logic [2:0] rom [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) spr_data <= rom[spr_addr];

  sprite_plotter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_erase(req_erase),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .done(done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: pixel k lands at origin + (k mod W, k div W), clipped to the screen.
  function automatic bit exp_plot(input int ox, input int oy, input bit e, input int k);
    bit on;
    on = ((ox + k % NW) < 160) && ((oy + k / NW) < 120);
`ifdef SPRITE_TRANSPARENT_EN
    if (!e && rom[k] == 3'd0) on = 1'b0;
`endif
    return on;
  endfunction

  task automatic accept_req(input int x, input int y, input bit e);
    req_x     = 8'(x);
    req_y     = 7'(y);
    req_erase = e;
    req_valid = 1'b1;
    check("ready_pre", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    $display("req  x=%0d y=%0d erase=%0d", x, y, e);
  endtask

  // Called #1 after the accept edge; returns #1 after E_{N+1}.
  task automatic scan_check(input int ox, input int oy, input bit e, output int plots);
    int  exp_plots;
    int  p;
    bit  ep;
    plots     = 0;
    exp_plots = 0;
    for (int k = 1; k <= N + 1; k++) begin
      @(posedge clk); #1;
      if (k < N) check($sformatf("addr[%0d]", k), int'(spr_addr), k);
      check($sformatf("ready[E%0d]", k), int'(req_ready), (k == N + 1) ? 1 : 0);
      check($sformatf("done[E%0d]", k), int'(done), (k == N + 1) ? 1 : 0);
      if (k == 1) check("plot[E1]", int'(vga_plot), 0);
      if (k >= 2) begin
        p  = k - 2;
        ep = exp_plot(ox, oy, e, p);
        check($sformatf("plot[%0d]", p), int'(vga_plot), int'(ep));
        if (ep) begin
          check($sformatf("x[%0d]", p), int'(vga_x), ox + p % NW);
          check($sformatf("y[%0d]", p), int'(vga_y), oy + p / NW);
          check($sformatf("col[%0d]", p), int'(vga_colour), e ? 0 : int'(rom[p]));
        end
        plots     += int'(vga_plot);
        exp_plots += int'(ep);
      end
    end
    check("plot_count", plots, exp_plots);
    $display("scan x=%0d y=%0d erase=%0d plots=%0d expected=%0d", ox, oy, e, plots, exp_plots);
  endtask

  initial begin
    int plots;
    int bad_plot;
    int bad_done;
    int rx, ry, gap;
    bit re;

    resetn    = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_erase = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = 3'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(req_ready), 1);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(spr_addr), 0);
    check("rst_x", int'(vga_x), 0);
    check("rst_y", int'(vga_y), 0);
    check("rst_col", int'(vga_colour), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Draw at (10,20), ROM[k] = k[2:0].
    accept_req(10, 20, 1'b0);
    scan_check(10, 20, 1'b0, plots);
`ifdef SPRITE_TRANSPARENT_EN
    check("draw_plots", plots, 56);
`else
    check("draw_plots", plots, 64);
`endif

    // Erase clipped at the bottom-right corner.
    @(posedge clk); #1;
    accept_req(156, 118, 1'b1);
    scan_check(156, 118, 1'b1, plots);
    check("erase_plots", plots, 8);

    // Transparency: only ROM[5] is colour 0.
    for (int i = 0; i < N; i++) rom[i] = 3'(1 + i % 7);
    rom[5] = 3'd0;
    @(posedge clk); #1;
    accept_req(10, 20, 1'b0);
    scan_check(10, 20, 1'b0, plots);
`ifdef SPRITE_TRANSPARENT_EN
    check("transp_plots", plots, 63);
`else
    check("transp_plots", plots, 64);
`endif

    // Second request held while busy; accepted on the first idle edge.
    accept_req(10, 20, 1'b0);
    req_x     = 8'd30;
    req_y     = 7'd40;
    req_erase = 1'b0;
    req_valid = 1'b1;
    scan_check(10, 20, 1'b0, plots);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scan_check(30, 40, 1'b0, plots);

    // Reset mid-scan at E32.
    @(posedge clk); #1;
    accept_req(10, 20, 1'b0);
    repeat (31) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_plot", int'(vga_plot), 0);
    check("midrst_ready", int'(req_ready), 1);
    check("midrst_done", int'(done), 0);
    check("midrst_addr", int'(spr_addr), 0);
    resetn   = 1'b1;
    bad_plot = 0;
    bad_done = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      bad_plot += int'(vga_plot);
      bad_done += int'(done);
    end
    check("post_rst_plots", bad_plot, 0);
    check("post_rst_done", bad_done, 0);
    accept_req(10, 20, 1'b0);
    scan_check(10, 20, 1'b0, plots);

    // Randomized requests with fresh ROM contents.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) rom[i] = 3'($urandom_range(0, 7));
      rx  = int'($urandom_range(0, 255));
      ry  = int'($urandom_range(0, 127));
      re  = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      #1;
      accept_req(rx, ry, re);
      scan_check(rx, ry, re, plots);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Pixel-scan engine that sits between the animation controller and the VGA adapter. It accepts one draw-or-erase request per sprite position, as an origin plus an erase flag. It then walks a W×H sprite rectangle in row-major order, fetching each pixel from a synchronous sprite ROM and emitting one clipped pixel write per cycle to the adapter. When the rectangle is finished it pulses `done` so the animation FSM can advance from its erase step to its draw step.

## Interface
- `W`, 8: sprite width in pixels.
- `H`, 8: sprite height in pixels.
- `ADDR_W`, 6: sprite ROM address width; must satisfy 2^ADDR_W ≥ W*H.
- `SCREEN_W`, 160: visible columns.
- `SCREEN_H`, 120: visible rows.
- `BG_COLOUR`, 3'b000: colour written on erase.
- `clk` in 1: system clock (CLOCK_50).
- `resetn` in 1: reset, synchronous, active-low; clock clk.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_x` in 8: origin column.
- `req_y` in 7: origin row.
- `req_erase` in 1: 1 = erase with BG_COLOUR, 0 = draw from ROM.
- `spr_addr` out ADDR_W: ROM address, equal to cy*W+cx.
- `spr_data` in 3: ROM colour, registered by the ROM one cycle after `spr_addr`.
- `vga_x` out 8: pixel column to the adapter.
- `vga_y` out 7: pixel row to the adapter.
- `vga_colour` out 3: pixel colour to the adapter.
- `vga_plot` out 1: write strobe to the adapter.
- `done` out 1: one-cycle pulse when a request completes.

## Operation
- **Accept:** a request is accepted at the edge where `req_valid && req_ready`.
  - `req_x`, `req_y` and `req_erase` are captured into internal registers.
  - Column counter `cx` and row counter `cy` are cleared.
  - State goes IDLE→SCAN.
- **SCAN, one pixel per cycle:**
  - `spr_addr` = cy*W+cx.
  - Stage-1 registers capture px = ox+cx (9 bits), py = oy+cy (8 bits), and a valid bit.
  - `cx` increments. At cx=W-1 it wraps to 0 and `cy` increments.
  - After pixel N-1 (N=W*H), state goes SCAN→FLUSH.
- **FLUSH:** lasts exactly one cycle, then the state goes to IDLE.
- **Output stage (registered):**
  - `vga_x` = px[7:0], `vga_y` = py[6:0].
  - `vga_colour` = BG_COLOUR if erase, otherwise `spr_data`.
  - `vga_plot` = stage-1 valid && px<SCREEN_W && py<SCREEN_H.
- **Clipping:** off-screen pixels keep their time slot with `vga_plot` low. Coordinates never wrap, so 9-bit and 8-bit sums are compared.
- **Requests while busy:** ignored. `req_ready` is low, and the requester holds `req_valid`.
- **Reset values** (any edge with resetn=0), including mid-scan:
  - state IDLE, `req_ready` 1.
  - `vga_x`, `vga_y`, `vga_colour`, `vga_plot`, `done`, `spr_addr`, counters and stage-1 valid all 0.
  - A reset mid-scan aborts the scan; no `done` is emitted and no further plots occur.

## Timing
- E0 is the accept edge.
- Address k (k=0..N-1) is presented during the cycle following E_k.
- Pixel k has `vga_plot`/`vga_x`/`vga_y`/`vga_colour` valid during the cycle following E_{k+2}. Latency is 2 cycles; throughput is 1 pixel per clock.
- After E_{N+1}:
  - the last pixel is on the outputs;
  - `done`=1 for exactly that cycle;
  - the state is IDLE, so `req_ready`=1.
- The earliest next accept is E_{N+2}.
- Request-to-request occupancy is N+2 cycles (66 at defaults).

## Configuration
- **Macro:** `SPRITE_TRANSPARENT_EN`.
- **Defined:** during a draw (not an erase), a pixel whose `spr_data` == 3'b000 has `vga_plot` forced low. This leaves the background intact. Timing is unchanged.
- **Undefined:** 3'b000 is an ordinary colour and is plotted like any other.

## Test plan
- **Draw:** defaults, draw at (10,20) with ROM[k]=k[2:0].
  - First plot after E2: (10,20), colour 0.
  - Last plot after E65: (17,27), colour 7.
  - `done` after E65 only; 64 plots total.
- **Erase with clipping:** erase at (156,118).
  - Exactly 8 plots (x 156–159, y 118–119), all with colour BG_COLOUR.
  - 56 clipped slots; `done` still after E65.
- **Transparency:** ROM[5]=0, draw at (10,20).
  - Macro defined: no plot at (15,20); 63 plots.
  - Macro undefined: plot at (15,20) with colour 0; 64 plots.
- **Hold while busy:** `req_valid` held high throughout with a second origin (30,40).
  - `req_ready` is low from E1 to E65.
  - The second request is accepted at E66; its first plot at (30,40) follows E68.
- **Reset mid-scan:** resetn=0 at E32 of a draw.
  - `vga_plot`=0 from then on, `req_ready`=1, `done` never pulses.
  - A new request after resetn=1 scans from pixel 0.
